// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the dma_copy block-copy engine:
//   - DMA_ADDR_W / DMA_DATA_W : default address and data bus widths
//   - ROM_BASE                : first address of the write-ignored ROM window
//   - dma_state_e             : controller state encoding
//   - is_rom()                : helper telling whether an address is in ROM
// Optional feature macro used by the files that import this package:
//   DMA_FILL_EN (adds the constant-fill mode).
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam int DMA_ADDR_W = 16;
    localparam int DMA_DATA_W = 8;

    localparam logic [15:0] ROM_BASE = 16'hE000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } dma_state_e;

    // Writes at or above ROM_BASE are issued on the bus but land nowhere.
    function automatic logic is_rom(input logic [15:0] addr);
        return addr >= ROM_BASE;
    endfunction

endpackage

// File: rtl/dma_if.sv
// -----------------------------------------------------------------------------
// dma_if
// Command/status interface between a requester (CPU, monitor) and dma_copy.
//   start     : one-cycle start pulse
//   src_addr  : first source address
//   dst_addr  : first destination address
//   length    : byte count (0 = no transfer)
//   busy      : engine is working on a copy
//   done      : one-cycle completion pulse
//   fill_mode : (DMA_FILL_EN only) write fill_byte instead of copying
//   fill_byte : (DMA_FILL_EN only) constant written in fill mode
// Modports: slave = the engine, master = the requester.
// -----------------------------------------------------------------------------
interface dma_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();

    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;
`ifdef DMA_FILL_EN
    logic              fill_mode;
    logic [DATA_W-1:0] fill_byte;
`endif

    modport slave (
`ifdef DMA_FILL_EN
        input  fill_mode, fill_byte,
`endif
        input  start, src_addr, dst_addr, length,
        output busy, done
    );

    modport master (
`ifdef DMA_FILL_EN
        output fill_mode, fill_byte,
`endif
        output start, src_addr, dst_addr, length,
        input  busy, done
    );

endinterface

// File: rtl/dma_addr_ctr.sv
// -----------------------------------------------------------------------------
// dma_addr_ctr
// Loadable W-bit incrementing address counter; wraps modulo 2**W.
//   clk      : system clock
//   reset    : synchronous, active-high reset (value -> 0)
//   load     : load load_val (has priority over inc)
//   load_val : value loaded when load=1
//   inc      : add one
//   value    : current counter value
// -----------------------------------------------------------------------------
module dma_addr_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);   // natural wrap 0xFFFF -> 0x0000
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/dma_copy.sv
// -----------------------------------------------------------------------------
// dma_copy
// Bus-initiator block-copy engine. On start it requests the memory bus, then
// alternates READ (source address, mem_outn low) and WRITE (destination
// address, mem_writen low) cycles until the byte count is exhausted.
//
// Ports:
//   clk        : system clock, all state changes on posedge
//   reset      : synchronous, active-high reset
//   ctl        : dma_if.slave command/status (start, src_addr, dst_addr,
//                length, busy, done [, fill_mode, fill_byte])
//   bus_req    : bus ownership request to the arbiter
//   bus_grant  : arbiter grant
//   abus       : address bus, driven only in READ/WRITE, else high-Z
//   mbus       : data bus, driven only in WRITE, else high-Z
//   mem_outn   : active-low read strobe
//   mem_writen : active-low write strobe
//
// Optional feature macro: DMA_FILL_EN. When defined, fill_mode/fill_byte are
// latched on start; fill mode skips READ and writes fill_byte every cycle.
// -----------------------------------------------------------------------------
module dma_copy
    import dma_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    dma_if.slave              ctl,
    output logic              bus_req,
    input  logic              bus_grant,
    inout  wire  [ADDR_W-1:0] abus,
    inout  wire  [DATA_W-1:0] mbus,
    output logic              mem_outn,
    output logic              mem_writen
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_REQ   = ST_REQ;
    localparam logic [2:0] S_READ  = ST_READ;
    localparam logic [2:0] S_WRITE = ST_WRITE;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] src_cur, dst_cur;
    logic              accept;       // start taken with a non-zero length
    logic              step;         // a byte finishes this cycle
    logic              fill_active;
    logic [DATA_W-1:0] wr_data;
    logic              abus_en, mbus_en;
    logic [ADDR_W-1:0] abus_out;

    // ------------------------------------------------------------------------
    // Optional fill mode
    // ------------------------------------------------------------------------
`ifdef DMA_FILL_EN
    logic              fill_q;
    logic [DATA_W-1:0] fill_byte_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q      <= 1'b0;
            fill_byte_q <= '0;
        end else if (accept) begin
            fill_q      <= ctl.fill_mode;
            fill_byte_q <= ctl.fill_byte;
        end
    end

    assign fill_active = fill_q;
    assign wr_data     = fill_q ? fill_byte_q : data_q;
`else
    assign fill_active = 1'b0;
    assign wr_data     = data_q;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        data_d  = data_q;
        accept  = 1'b0;
        step    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctl.start) begin
                    if (ctl.length != '0) begin
                        accept  = 1'b1;
                        len_d   = ctl.length;
                        state_d = S_REQ;
                    end else begin
                        // Empty copy: finish without ever touching the bus.
                        state_d = S_DONE;
                    end
                end
            end

            S_REQ: begin
                if (bus_grant) begin
                    state_d = fill_active ? S_WRITE : S_READ;
                end
            end

            S_READ: begin
                data_d  = mbus;
                state_d = S_WRITE;
            end

            S_WRITE: begin
                step  = 1'b1;
                len_d = len_q - ADDR_W'(1);
                // Grant is only re-examined here, so a READ/WRITE pair is
                // never split by the arbiter.
                if (len_q == ADDR_W'(1)) begin
                    state_d = S_DONE;
                end else if (bus_grant) begin
                    state_d = fill_active ? S_WRITE : S_READ;
                end else begin
                    state_d = S_REQ;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Source / destination address counters
    // ------------------------------------------------------------------------
    dma_addr_ctr #(.W(ADDR_W)) u_src_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (ctl.src_addr),
        .inc      (step),
        .value    (src_cur)
    );

    dma_addr_ctr #(.W(ADDR_W)) u_dst_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (ctl.dst_addr),
        .inc      (step),
        .value    (dst_cur)
    );

    // ------------------------------------------------------------------------
    // Outputs and bus drivers (pure decode of the registered state)
    // ------------------------------------------------------------------------
    assign ctl.busy   = (state_q == S_REQ) || (state_q == S_READ) || (state_q == S_WRITE);
    assign ctl.done   = (state_q == S_DONE);
    assign bus_req    = ctl.busy;
    assign mem_outn   = (state_q != S_READ);
    assign mem_writen = (state_q != S_WRITE);

    assign abus_en  = (state_q == S_READ) || (state_q == S_WRITE);
    assign mbus_en  = (state_q == S_WRITE);
    assign abus_out = (state_q == S_READ) ? src_cur : dst_cur;

    assign abus = abus_en ? abus_out : {ADDR_W{1'bz}};
    assign mbus = mbus_en ? wr_data  : {DATA_W{1'bz}};

    // Simulation-only sanity check: a READ must return a defined byte.
    always @(posedge clk) begin
        if (!reset && (state_q == S_READ)) begin
            assert (!$isunknown(mbus))
                else $error("dma_copy: undefined data on mbus reading 0x%h", src_cur);
        end
    end

endmodule

// File: tb/tb_dma_copy.sv
// -----------------------------------------------------------------------------
// tb_dma_copy
// Self-checking bench for dma_copy. A 64 KiB memory with a write-ignored ROM
// window answers the engine's bus cycles; a reference memory plus an expected
// list of bus operations (read addr / write addr+data) is derived from the
// copy rules and compared against every strobe the engine issues.
// -----------------------------------------------------------------------------
module tb_dma_copy;
    import dma_pkg::*;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } op_t;

    logic       clk;
    logic       reset;
    logic       bus_req;
    logic       bus_grant;
    logic       mem_outn;
    logic       mem_writen;
    wire [15:0] abus;
    wire [7:0]  mbus;

    dma_if #(.ADDR_W(16), .DATA_W(8)) ctl ();

    dma_copy #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .ctl        (ctl),
        .bus_req    (bus_req),
        .bus_grant  (bus_grant),
        .abus       (abus),
        .mbus       (mbus),
        .mem_outn   (mem_outn),
        .mem_writen (mem_writen)
    );

    logic [7:0] mem     [0:65535];   // the memory the engine talks to
    logic [7:0] ref_mem [0:65535];   // what that memory must end up holding
    op_t        exp_q [$];
    op_t        cmp_op;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;
    bit saw_req = 0;
    bit saw_rd  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: drives data while read strobe is low.
    assign mbus = (!mem_outn) ? mem[abus] : 8'bz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process and write commit, on the falling edge (clock-high phase
    // of the WRITE cycle has just ended).
    always @(negedge clk) begin
        if (cmp_en) begin
            if (bus_req)   saw_req = 1'b1;
            if (!mem_outn) saw_rd  = 1'b1;
            check("req_vs_busy", 32'(bus_req), 32'(ctl.busy));
            check("done_not_busy", 32'(ctl.done & ctl.busy), 32'h0);
            if (!mem_outn || !mem_writen) begin
                check("op_expected", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    cmp_op = exp_q.pop_front();
                    check("op_kind", 32'({mem_outn, mem_writen}), cmp_op.wr ? 32'h2 : 32'h1);
                    check("op_addr", 32'(abus), 32'(cmp_op.addr));
                    if (!mem_writen) check("op_data", 32'(mbus), 32'(cmp_op.data));
                end
            end
        end
        if (!mem_writen && !is_rom(abus)) mem[abus] = mbus;
    end

    // Reference copy: forward, byte by byte, 16-bit wrapping addresses.
    task automatic model_build(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                               input bit fill, input logic [7:0] fb);
        logic [15:0] a, w;
        logic [7:0]  v;
        for (int i = 0; i < int'(l); i++) begin
            a = s + 16'(i);
            w = d + 16'(i);
            if (fill) begin
                v = fb;
            end else begin
                v = ref_mem[a];
                exp_q.push_back('{1'b0, a, v});
            end
            exp_q.push_back('{1'b1, w, v});
            if (!is_rom(w)) ref_mem[w] = v;
        end
    endtask

    // Called at a sample point; returns at the sample point after the
    // accepting edge (cycle 1 of the transfer).
    task automatic drive_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                               input bit fill, input logic [7:0] fb);
        ctl.start    = 1'b1;
        ctl.src_addr = s;
        ctl.dst_addr = d;
        ctl.length   = l;
`ifdef DMA_FILL_EN
        ctl.fill_mode = fill;
        ctl.fill_byte = fb;
`else
        if (fill) $display("fill request ignored: DMA_FILL_EN not defined (0x%0h)", fb);
`endif
        @(posedge clk); #1;
        ctl.start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_done(input int budget, input bit rgrant, output int lat);
        lat = 1;
        while (!ctl.done && lat < budget) begin
            if (rgrant) bus_grant = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", 32'(ctl.done), 32'h1);
        if (!ctl.done) do_reset();
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) n++;
        return n;
    endfunction

    task automatic finish_checks(input int lat, input int exp_lat);
        if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        check("done_pulse", 32'(ctl.done), 32'h0);
        check("idle_busy", 32'(ctl.busy), 32'h0);
        check("ops_left", 32'(exp_q.size()), 32'h0);
        check("mem_image", 32'(mem_diffs()), 32'h0);
        exp_q.delete();
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // Global time bound.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] s, d, l;
        logic [7:0]  rom_keep;
        bit          fill;

        reset        = 1'b1;
        bus_grant    = 1'b0;
        ctl.start    = 1'b0;
        ctl.src_addr = '0;
        ctl.dst_addr = '0;
        ctl.length   = '0;
`ifdef DMA_FILL_EN
        ctl.fill_mode = 1'b0;
        ctl.fill_byte = '0;
`endif
        for (int a = 0; a < 65536; a++) preload(16'(a), 8'($urandom));

        repeat (3) @(posedge clk);
        #1;
        // Reset values.
        check("rst_busy",   32'(ctl.busy),   32'h0);
        check("rst_done",   32'(ctl.done),   32'h0);
        check("rst_req",    32'(bus_req),    32'h0);
        check("rst_outn",   32'(mem_outn),   32'h1);
        check("rst_writen", 32'(mem_writen), 32'h1);
        reset  = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk); #1;

        // ---- Basic copy, grant tied high ----
        preload(16'h0100, 8'h11);
        preload(16'h0101, 8'h22);
        preload(16'h0102, 8'h33);
        preload(16'h0103, 8'h44);
        bus_grant = 1'b1;
        model_build(16'h0100, 16'h8000, 16'd4, 1'b0, 8'h00);
        drive_start(16'h0100, 16'h8000, 16'd4, 1'b0, 8'h00);
        wait_done(200, 1'b0, lat);
        finish_checks(lat, 10);
        check("copy_8000", 32'(mem[16'h8000]), 32'h11);
        check("copy_8001", 32'(mem[16'h8001]), 32'h22);
        check("copy_8002", 32'(mem[16'h8002]), 32'h33);
        check("copy_8003", 32'(mem[16'h8003]), 32'h44);

        // ---- Zero length: no bus request at all ----
        saw_req = 1'b0;
        drive_start(16'h0100, 16'h8100, 16'd0, 1'b0, 8'h00);
        wait_done(50, 1'b0, lat);
        finish_checks(lat, 1);
        check("zero_no_req", 32'(saw_req), 32'h0);

        // ---- Address wrap ----
        preload(16'hFFFE, 8'hC1);
        preload(16'hFFFF, 8'hC2);
        preload(16'h0000, 8'hC3);
        preload(16'h0001, 8'hC4);
        model_build(16'hFFFE, 16'h7FFF, 16'd4, 1'b0, 8'h00);
        drive_start(16'hFFFE, 16'h7FFF, 16'd4, 1'b0, 8'h00);
        wait_done(200, 1'b0, lat);
        finish_checks(lat, 10);
        check("wrap_7fff", 32'(mem[16'h7FFF]), 32'hC1);
        check("wrap_8000", 32'(mem[16'h8000]), 32'hC2);
        check("wrap_8001", 32'(mem[16'h8001]), 32'hC3);
        check("wrap_8002", 32'(mem[16'h8002]), 32'hC4);

        // ---- Grant withdrawn during the second WRITE ----
        model_build(16'h0100, 16'h9000, 16'd4, 1'b0, 8'h00);
        drive_start(16'h0100, 16'h9000, 16'd4, 1'b0, 8'h00);
        lat = 1;
        while (!ctl.done && lat < 100) begin
            if (lat == 5) begin
                check("wd_in_write2", 32'(mem_writen), 32'h0);
                bus_grant = 1'b0;
            end
            if (lat >= 6 && lat <= 8) begin
                check("wd_req_held", 32'(bus_req), 32'h1);
                check("wd_no_strobe", 32'({mem_outn, mem_writen}), 32'h3);
            end
            if (lat == 8) bus_grant = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", 32'(ctl.done), 32'h1);
        finish_checks(lat, 13);
        check("wd_9000", 32'(mem[16'h9000]), 32'h11);
        check("wd_9003", 32'(mem[16'h9003]), 32'h44);

        // ---- Reset during the third READ ----
        preload(16'hA002, 8'h77);
        model_build(16'h0100, 16'hA000, 16'd2, 1'b0, 8'h00);
        exp_q.push_back('{1'b0, 16'h0102, ref_mem[16'h0102]});
        drive_start(16'h0100, 16'hA000, 16'd4, 1'b0, 8'h00);
        lat = 1;
        while (lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rst_in_read3", 32'(mem_outn), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rmid_busy",   32'(ctl.busy),   32'h0);
        check("rmid_req",    32'(bus_req),    32'h0);
        check("rmid_strobe", 32'({mem_outn, mem_writen}), 32'h3);
        repeat (5) begin
            check("rmid_no_done", 32'(ctl.done), 32'h0);
            @(posedge clk); #1;
        end
        check("ops_left", 32'(exp_q.size()), 32'h0);
        check("mem_image", 32'(mem_diffs()), 32'h0);
        check("rmid_a000", 32'(mem[16'hA000]), 32'h11);
        check("rmid_a001", 32'(mem[16'hA001]), 32'h22);
        check("rmid_a002", 32'(mem[16'hA002]), 32'h77);
        exp_q.delete();

        // ---- Copy straddling the ROM window ----
        rom_keep = mem[16'hE000];
        model_build(16'h0100, 16'hDFFE, 16'd4, 1'b0, 8'h00);
        drive_start(16'h0100, 16'hDFFE, 16'd4, 1'b0, 8'h00);
        wait_done(200, 1'b0, lat);
        finish_checks(lat, 10);
        check("rom_dfff", 32'(mem[16'hDFFF]), 32'h22);
        check("rom_e000", 32'(mem[16'hE000]), 32'(rom_keep));

`ifdef DMA_FILL_EN
        // ---- Fill mode ----
        saw_rd = 1'b0;
        model_build(16'h0000, 16'h0200, 16'd3, 1'b1, 8'hA5);
        drive_start(16'h1234, 16'h0200, 16'd3, 1'b1, 8'hA5);
        wait_done(100, 1'b0, lat);
        finish_checks(lat, 5);
        check("fill_no_read", 32'(saw_rd), 32'h0);
        check("fill_0200", 32'(mem[16'h0200]), 32'hA5);
        check("fill_0202", 32'(mem[16'h0202]), 32'hA5);
`endif

        // ---- Randomised copies with a random arbiter ----
        for (int t = 0; t < 14; t++) begin
            s = 16'($urandom);
            l = 16'($urandom_range(0, 24));
            if ($urandom_range(0, 1) == 1) begin
                d = s - 16'($urandom_range(0, 30));
            end else begin
                d = 16'($urandom);
                if (16'(d - s) < l) d = s - l;
            end
            fill = 1'b0;
`ifdef DMA_FILL_EN
            fill = ($urandom_range(0, 3) == 0);
`endif
            model_build(s, d, l, fill, 8'($urandom));
            drive_start(s, d, l, fill, (exp_q.size() != 0) ? exp_q[$].data : 8'h00);
            wait_done(2000, 1'b1, lat);
            finish_checks(lat, -1);
        end

        bus_grant = 1'b1;
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_copy.md
Name: dma_copy

Overview:
- Bus-initiator block-copy engine: the master on the same abus/mbus/outn/writen memory interface the memory module responds to.
- On a start request it arbitrates for the bus, then alternates READ cycles (source address, output strobe) and WRITE cycles (destination address, write strobe) until the byte count reaches zero.
- Used by the monitor/BIOS to copy ROM images into RAM and to move buffers without CPU involvement.

Parameters:
- ADDR_W, 16, address width; matches abus.
- DATA_W, 8, data width; matches mbus.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- src_addr  input  16  first source address, latched on start.
- dst_addr  input  16  first destination address, latched on start.
- length  input  16  byte count, latched on start; 0 means no transfer.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse on completion.
- bus_req  output  1  bus ownership request to the arbiter.
- bus_grant  input  1  arbiter grant.
- abus  inout  16  address bus; driven only while owning the bus, else high-Z.
- mbus  inout  8  data bus; driven only in WRITE, else high-Z.
- mem_outn  output  1  active-low read strobe; 1 when not in READ.
- mem_writen  output  1  active-low write strobe; 1 when not in WRITE.

Behaviour:
- Reset values: busy=0, done=0, bus_req=0, mem_outn=1, mem_writen=1, abus=Z, mbus=Z, state=IDLE. Reset mid-transfer abandons the copy at the next edge; no done pulse.
- States: IDLE, REQ, READ, WRITE, DONE.
- IDLE:
  - start=1 with length≠0: latch src/dst/len, go to REQ.
  - start=1 with length=0: go to DONE directly; bus is never requested.
- REQ: bus_req=1. Go to READ on the edge where bus_grant=1.
- READ (1 cycle):
  - abus=src, mem_outn=0, mem_writen=1.
  - mbus captured into the data register at the closing posedge.
  - If captured mbus contains X/Z, flag a simulation $error.
  - Always go to WRITE.
- WRITE (1 cycle):
  - abus=dst, mbus=data register, mem_writen=0, mem_outn=1.
  - The memory commits during the clock-high phase of this cycle.
  - On exit: src+=1, dst+=1, len-=1.
  - len reaches 0 → DONE.
  - Else if bus_grant=1 → READ.
  - Else drop drive (abus/mbus=Z) → REQ.
- Grant withdrawal is honoured only at byte boundaries; a READ/WRITE pair is never split. bus_req stays high through REQ/READ/WRITE.
- DONE: done=1 for one cycle, bus_req=0, bus released, → IDLE. busy=0 in IDLE and DONE.
- Address counters are ADDR_W-bit modulo: 0xFFFF+1 wraps to 0x0000. Writes into the ROM window (0xE000–0xFFFF) are issued but have no effect; this is not an error.
- Throughput: 2 cycles per byte plus 1 arbitration cycle per grant.
- Overlapping regions copy forward, byte by byte. The result is defined for dst≤src or non-overlapping regions only.

Optional Feature:
- Macro DMA_FILL_EN.
- Defined:
  - Adds input fill_mode (1) and fill_byte (8), latched on start.
  - With fill_mode=1, READ is skipped: REQ/WRITE go directly to WRITE.
  - WRITE drives fill_byte; src is ignored; 1 cycle per byte.
- Undefined: ports absent; copy behaviour only.

Decomposition:
- Package dma_pkg: state enum (IDLE, REQ, READ, WRITE, DONE), ADDR_W/DATA_W defaults, ROM_BASE=16'hE000 for bench checks.
- Sub-module dma_addr_ctr: loadable 16-bit incrementing counter with wrap. Instantiated twice (src, dst); the len down-counter stays inline.

Test Plan:
- Copy: preload RAM 0x0100..0x0103 = 11,22,33,44; start with src=0x0100, dst=0x8000, len=4, grant tied high → 0x8000..0x8003 = 11,22,33,44; done 10 cycles after start (1 REQ + 8 + 1 DONE).
- Zero length: start with len=0 → bus_req never asserts; done pulses 1 cycle after start; abus stays Z.
- Wrap: start with src=0xFFFE, dst=0x7FFF, len=4 → reads from 0xFFFE, 0xFFFF, 0x0000, 0x0001; writes to 0x7FFF, 0x8000, 0x8001, 0x8002; no X on abus.
- Grant withdrawal: drop bus_grant during the second WRITE → that write completes; abus/mbus go Z; state REQ until grant returns; final memory contents match the copy test.
- Reset mid-copy: assert reset in the third READ → next cycle busy=0, bus_req=0, strobes=1, buses Z; only the first two destination bytes changed; no done pulse.
- Fill (DMA_FILL_EN defined): start with fill_mode=1, fill_byte=0xA5, dst=0x0200, len=3 → 0x0200..0x0202 = A5; mem_outn never asserts low; done 5 cycles after start.
